// File: rtl/clock_switch_ctrl.sv
// Break-before-make one-hot clock enable controller; optional CLKSW_FALLBACK_EN adds FAIL-driven return to DEF_CH.
// Switch latency DEAD_CYC+1 cycles; REQ_READY held low while a switch is in flight so requests wait, never drop.
module clock_switch_ctrl #(
  parameter int N_CH     = 4,
  parameter int SEL_W    = $clog2(N_CH),
  parameter int DEAD_CYC = 2,
  parameter int DEF_CH   = 0
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             REQ_VALID,
  input  logic [SEL_W-1:0] REQ_SEL,
  output logic             REQ_READY,
  output logic [N_CH-1:0]  EN,
  output logic [SEL_W-1:0] ACT_SEL,
  output logic             BUSY,
  output logic             ERR
`ifdef CLKSW_FALLBACK_EN
  ,
  input  logic [N_CH-1:0]  FAIL
`endif
);

  localparam int               CNT_W    = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N_CH-1:0]  OH_ONE   = N_CH'(1);
  localparam logic [N_CH-1:0]  DEF_OH   = OH_ONE << DEF_CH;
  localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEF_CH);
  localparam logic [SEL_W:0]   NCH_V    = (SEL_W + 1)'(N_CH);

  typedef enum logic [1:0] {IDLE, DEAD, ARM} state_t;

  state_t           r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [SEL_W-1:0] r_tgt, w_nxt_tgt;
  logic [SEL_W-1:0] r_act_sel, w_nxt_act;
  logic [N_CH-1:0]  r_en, w_nxt_en;
  logic             r_err, w_nxt_err;
  logic             w_fb_go;
  logic             w_accept;
  logic             w_oor;
  logic [N_CH-1:0]  w_tgt_oh;

`ifdef CLKSW_FALLBACK_EN
  // A failing non-default clock pre-empts any request presented in the same cycle.
  assign w_fb_go = (r_state == IDLE) && FAIL[r_act_sel] && (r_act_sel != DEF_SEL);
`else
  assign w_fb_go = 1'b0;
`endif

  assign REQ_READY = (r_state == IDLE) && !w_fb_go;
  assign BUSY      = ~REQ_READY;
  assign EN        = r_en;
  assign ACT_SEL   = r_act_sel;
  assign ERR       = r_err;

  assign w_accept  = REQ_VALID && REQ_READY;
  assign w_oor     = ({1'b0, REQ_SEL} >= NCH_V);
  assign w_tgt_oh  = OH_ONE << r_tgt;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_tgt   = r_tgt;
    w_nxt_en    = r_en;
    w_nxt_act   = r_act_sel;
    w_nxt_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fb_go) begin
          w_nxt_tgt   = DEF_SEL;
          w_nxt_state = DEAD;
          w_nxt_en    = '0;
          w_nxt_cnt   = CNT_LOAD;
        end else if (w_accept) begin
          if (w_oor) begin
            w_nxt_err = 1'b1;
          end else if (REQ_SEL != r_act_sel) begin
            w_nxt_tgt   = REQ_SEL;
            w_nxt_state = DEAD;
            w_nxt_en    = '0;
            w_nxt_cnt   = CNT_LOAD;
          end
        end
      end
      // The ARM load happens on the same edge that leaves DEAD, so ARM is never resident.
      DEAD: begin
        if (r_cnt == '0) begin
          w_nxt_state = IDLE;
          w_nxt_en    = w_tgt_oh;
          w_nxt_act   = r_tgt;
        end else begin
          w_nxt_cnt = r_cnt - CNT_ONE;
        end
      end
      ARM: begin
        w_nxt_state = IDLE;
        w_nxt_en    = w_tgt_oh;
        w_nxt_act   = r_tgt;
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_tgt     <= DEF_SEL;
      r_act_sel <= DEF_SEL;
      r_en      <= DEF_OH;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_tgt     <= w_nxt_tgt;
      r_act_sel <= w_nxt_act;
      r_en      <= w_nxt_en;
      r_err     <= w_nxt_err;
    end
  end

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Directed bench: main instance N_CH=4, second instance N_CH=3 for the out-of-range select.
module tb_clock_switch_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;

  logic       a_valid = 1'b0;
  logic [1:0] a_sel = 2'd0;
  logic       a_ready, a_busy, a_err;
  logic [3:0] a_en;
  logic [1:0] a_act;
`ifdef CLKSW_FALLBACK_EN
  logic [3:0] a_fail = 4'b0000;
  logic [2:0] b_fail = 3'b000;
`endif

  logic       b_valid = 1'b0;
  logic [1:0] b_sel = 2'd0;
  logic       b_ready, b_busy, b_err;
  logic [2:0] b_en;
  logic [1:0] b_act;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  clock_switch_ctrl #(.N_CH(4), .DEAD_CYC(2), .DEF_CH(0)) u_a (
    .CLK(clk), .RSTN(rstn), .REQ_VALID(a_valid), .REQ_SEL(a_sel), .REQ_READY(a_ready),
    .EN(a_en), .ACT_SEL(a_act), .BUSY(a_busy), .ERR(a_err)
`ifdef CLKSW_FALLBACK_EN
    , .FAIL(a_fail)
`endif
  );

  clock_switch_ctrl #(.N_CH(3), .DEAD_CYC(2), .DEF_CH(0)) u_b (
    .CLK(clk), .RSTN(rstn), .REQ_VALID(b_valid), .REQ_SEL(b_sel), .REQ_READY(b_ready),
    .EN(b_en), .ACT_SEL(b_act), .BUSY(b_busy), .ERR(b_err)
`ifdef CLKSW_FALLBACK_EN
    , .FAIL(b_fail)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  initial begin
    // reset
    nedge(); nedge();
    chk("rst_en", 32'(a_en), 32'h1);
    chk("rst_act", 32'(a_act), 32'h0);
    chk("rst_ready", 32'(a_ready), 32'h1);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_err", 32'(a_err), 32'h0);
    rstn = 1'b1;
    nedge();

    // switch 0 -> 2
    a_valid = 1'b1; a_sel = 2'd2;
    nedge();                                   // T+1
    a_valid = 1'b0;
    chk("sw2_en_t1", 32'(a_en), 32'h0);
    chk("sw2_ready_t1", 32'(a_ready), 32'h0);
    chk("sw2_busy_t1", 32'(a_busy), 32'h1);
    chk("sw2_act_t1", 32'(a_act), 32'h0);
    nedge();                                   // T+2
    chk("sw2_en_t2", 32'(a_en), 32'h0);
    chk("sw2_ready_t2", 32'(a_ready), 32'h0);
    nedge();                                   // T+3
    chk("sw2_en_t3", 32'(a_en), 32'h4);
    chk("sw2_act_t3", 32'(a_act), 32'h2);
    chk("sw2_ready_t3", 32'(a_ready), 32'h1);

    // same-channel request is a no-op
    a_valid = 1'b1; a_sel = 2'd2;
    nedge();
    a_valid = 1'b0;
    chk("noop_en", 32'(a_en), 32'h4);
    chk("noop_ready", 32'(a_ready), 32'h1);
    chk("noop_act", 32'(a_act), 32'h2);

    // out-of-range select on the 3-channel instance
    b_valid = 1'b1; b_sel = 2'd3;
    nedge();
    b_valid = 1'b0;
    chk("oor_err", 32'(b_err), 32'h1);
    chk("oor_en", 32'(b_en), 32'h1);
    chk("oor_ready", 32'(b_ready), 32'h1);
    nedge();
    chk("oor_err_drop", 32'(b_err), 32'h0);
    chk("oor_act", 32'(b_act), 32'h0);

    // request held through a switch to 3
    a_valid = 1'b1; a_sel = 2'd3;
    nedge();                                   // T+1
    a_sel = 2'd1;
    chk("hold_ready_t1", 32'(a_ready), 32'h0);
    chk("hold_en_t1", 32'(a_en), 32'h0);
    nedge();                                   // T+2
    chk("hold_ready_t2", 32'(a_ready), 32'h0);
    chk("hold_act_t2", 32'(a_act), 32'h2);
    nedge();                                   // T+3, SEL=1 accepted at next edge
    chk("hold_en_t3", 32'(a_en), 32'h8);
    chk("hold_act_t3", 32'(a_act), 32'h3);
    chk("hold_ready_t3", 32'(a_ready), 32'h1);
    nedge();
    a_valid = 1'b0;
    chk("hold2_en_t1", 32'(a_en), 32'h0);
    chk("hold2_ready_t1", 32'(a_ready), 32'h0);
    nedge();
    chk("hold2_en_t2", 32'(a_en), 32'h0);
    nedge();
    chk("hold2_en_t3", 32'(a_en), 32'h2);
    chk("hold2_act_t3", 32'(a_act), 32'h1);

    // async reset in the middle of DEAD
    a_valid = 1'b1; a_sel = 2'd2;
    nedge();
    a_valid = 1'b0;
    chk("mid_en_dead", 32'(a_en), 32'h0);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_en", 32'(a_en), 32'h1);
    chk("mid_rst_act", 32'(a_act), 32'h0);
    chk("mid_rst_ready", 32'(a_ready), 32'h1);
    nedge();
    rstn = 1'b1;
    nedge(); nedge(); nedge();
    chk("mid_discard_en", 32'(a_en), 32'h1);
    chk("mid_discard_act", 32'(a_act), 32'h0);

`ifdef CLKSW_FALLBACK_EN
    // move to ch 2, then fail it with a competing request for ch 1
    a_valid = 1'b1; a_sel = 2'd2;
    nedge();
    a_valid = 1'b0;
    nedge(); nedge();
    chk("fb_pre_en", 32'(a_en), 32'h4);
    a_fail = 4'b0100; a_valid = 1'b1; a_sel = 2'd1;
    #1;
    chk("fb_ready_forced", 32'(a_ready), 32'h0);
    nedge();                                   // T+1
    a_fail = 4'b0000;
    chk("fb_en_t1", 32'(a_en), 32'h0);
    chk("fb_ready_t1", 32'(a_ready), 32'h0);
    nedge();                                   // T+2
    chk("fb_en_t2", 32'(a_en), 32'h0);
    nedge();                                   // T+3
    chk("fb_en_t3", 32'(a_en), 32'h1);
    chk("fb_act_t3", 32'(a_act), 32'h0);
    chk("fb_ready_t3", 32'(a_ready), 32'h1);
    nedge();
    a_valid = 1'b0;
    nedge(); nedge();
    chk("fb_req_en", 32'(a_en), 32'h2);
    chk("fb_req_act", 32'(a_act), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
